axis_chan_rr_arbiter: RTL

//   Merges NUM_CH per-channel ADC sample streams (one per LTC2324 channel) into one AXI-Stream.
//   - Uses round-robin arbitration.
//   - Tags each beat with its source channel ID.
//   - Drives m_tlast at fixed frame boundaries.

---
 rtl/axis_chan_rr_arbiter_pkg.sv | 33 +++
 rtl/axis_chan_rr_arbiter_if.sv | 36 +++
 rtl/axis_chan_rr_arbiter_rr_pick.sv | 62 ++++++
 rtl/axis_chan_rr_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/axis_chan_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared constants and helpers for the per-channel AXI-Stream round-robin
// arbiter. The output beat layout is {zero pad, ch_id, sample}. The sample
// sits at bit 0 and the channel id sits directly above the sample.
// No ports (package).
// -----------------------------------------------------------------------------
package axis_arb_pkg;

  // Width of the channel-id tag carried in every output beat.
  localparam int CH_ID_W    = 8;
  // The sample always starts at bit 0 of the output beat.
  localparam int SAMPLE_LSB = 0;

  typedef logic [CH_ID_W-1:0] ch_id_t;

  // The tag starts right above the sample, so its offset is the sample width.
  function automatic int chid_lsb(input int s_width);
    return s_width;
  endfunction

  // Decodes a one-hot vector of up to 8 bits into an index.
  // A zero input returns 0.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axis_chan_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// axis_chan_rr_arbiter_if
// Bundles the NUM_CH input streams and the merged output stream.
//   s_tdata  : NUM_CH*S_WIDTH, channel i at [i*S_WIDTH +: S_WIDTH]
//   s_tvalid : per-channel valid
//   s_tready : per-channel ready (one-hot or zero)
//   m_tdata  : DATA_WIDTH merged beat {pad, ch_id, sample}
//   m_tvalid, m_tready, m_tlast : output handshake and frame marker
// The modport "slave" is the arbiter side. The modport "master" is the
// side that drives the channels and sinks the output.
// -----------------------------------------------------------------------------
interface axis_chan_rr_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int S_WIDTH    = 16,
  parameter int DATA_WIDTH = 32
);
  import axis_arb_pkg::*;

  logic [NUM_CH*S_WIDTH-1:0] s_tdata;
  logic [NUM_CH-1:0]         s_tvalid;
  logic [NUM_CH-1:0]         s_tready;
  logic [DATA_WIDTH-1:0]     m_tdata;
  logic                      m_tvalid;
  logic                      m_tready;
  logic                      m_tlast;

  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/axis_chan_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. It returns the first set bit of
// req at or after last+1, wrapping around at N.
//   req        in  N          request vector
//   last       in  clog2(N)   index of the previous winner
//   gnt_onehot out N          one-hot winner, zero when req is zero
//   gnt_idx    out clog2(N)   winner index, 0 when req is zero
// The picker works in three steps: rotate, priority-encode, unrotate.
// After rotation, the position right after the previous winner becomes
// bit 0. A plain lowest-bit priority encoder then gives the round-robin
// winner. The encoder result is finally shifted back to the real index.
// -----------------------------------------------------------------------------
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IDX_W = $clog2(N);

  int         w_start;
  int         w_off;
  int         w_idx;
  int         w_src;
  logic       w_hit;
  logic [N-1:0] w_rot;

  always_comb begin
    w_start = (int'(last) >= N - 1) ? 0 : int'(last) + 1;
    w_rot   = '0;
    for (int i = 0; i < N; i++) begin
      w_src = i + w_start;
      if (w_src >= N) w_src = w_src - N;
      w_rot[i] = req[w_src];
    end

    // Lowest set bit of the rotated vector; scanned downward so the last
    // hit that is written is the lowest one.
    w_off = 0;
    w_hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = i;
        w_hit = 1'b1;
      end
    end

    w_idx = w_off + w_start;
    if (w_idx >= N) w_idx = w_idx - N;
    gnt_idx = w_hit ? IDX_W'(w_idx) : '0;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign gnt_onehot[gi] = w_hit && (w_idx == gi);
  end

endmodule

// File: rtl/axis_chan_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_chan_rr_arbiter
// Merges NUM_CH ADC sample streams into a single AXI-Stream using
// round-robin arbitration. Every output beat is tagged with the id of its
// source channel. m_tlast marks every FRAME_LEN-th beat.
//   aclk     in   clock, rising edge
//   aresetn  in   synchronous active-low reset
//   enable   in   1 = arbitrate, 0 = grant nothing new
//   ch_mask  in   NUM_CH, 1 = channel eligible
//   bus      if   input streams and merged output (slave modport)
// The output is one register stage, so throughput is one beat per cycle.
// A new beat is loaded whenever the output slot is empty or is being
// drained on the same edge.
// -----------------------------------------------------------------------------
module axis_chan_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int S_WIDTH    = 16,
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 256
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  axis_chan_rr_arbiter_if.slave bus
);
  localparam int IDX_W    = $clog2(NUM_CH);
  localparam int CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CHID_LSB = chid_lsb(S_WIDTH);

  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic [IDX_W-1:0]      r_last_grant;
  logic [CNT_W-1:0]      r_beat_cnt;

  logic [S_WIDTH-1:0]    w_samples [NUM_CH];
  logic [NUM_CH-1:0]     w_req;
  logic [NUM_CH-1:0]     w_gnt_onehot;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_slot_free;
  logic                  w_fire;
  ch_id_t                w_ch_id;
  logic [DATA_WIDTH-1:0] w_beat;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_split
    assign w_samples[gi] = bus.s_tdata[gi*S_WIDTH +: S_WIDTH];
  end

  assign w_req       = bus.s_tvalid & ch_mask & {NUM_CH{enable}};
  assign w_slot_free = !r_m_tvalid || bus.m_tready;
  // Gating with aresetn keeps every channel un-ready in the reset cycle,
  // so no sample is consumed and then thrown away.
  assign w_fire      = aresetn && w_slot_free && (|w_req);

  rr_pick #(.N(NUM_CH)) u_pick (
    .req        (w_req),
    .last       (r_last_grant),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx)
  );

  assign bus.s_tready = w_fire ? w_gnt_onehot : '0;
  assign w_ch_id      = CH_ID_W'(w_gnt_idx);

  always_comb begin
    w_beat = '0;
    w_beat[SAMPLE_LSB +: S_WIDTH] = w_samples[w_gnt_idx];
    w_beat[CHID_LSB +: CH_ID_W]   = w_ch_id;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_m_tdata    <= '0;
      r_m_tvalid   <= 1'b0;
      r_m_tlast    <= 1'b0;
      r_last_grant <= IDX_W'(NUM_CH - 1);
      r_beat_cnt   <= '0;
    end else if (w_fire) begin
      r_m_tdata    <= w_beat;
      r_m_tvalid   <= 1'b1;
      // Frame position is fixed at load time and does not change while
      // the beat waits for m_tready.
      r_m_tlast    <= (r_beat_cnt == CNT_W'(FRAME_LEN - 1));
      r_beat_cnt   <= (r_beat_cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : r_beat_cnt + 1'b1;
      r_last_grant <= w_gnt_idx;
    end else if (bus.m_tready) begin
      r_m_tvalid   <= 1'b0;
    end
  end

  assign bus.m_tdata  = r_m_tdata;
  assign bus.m_tvalid = r_m_tvalid;
  assign bus.m_tlast  = r_m_tlast;

endmodule
